// File: rtl/uart_phy.sv
// 8N1 UART transceiver: RX pin to a one-byte valid/ready holding register,
// and a valid/ready byte stream to the TX pin. Fixed baud set by CLKS_PER_BIT.
module uart_phy #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       m_aresetn,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  // The idle cycle that accepts the next byte supplies the final stop-bit
  // cycle, so back-to-back frames are exactly 10*N cycles with no gap.
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  rx_state_t     rx_state_reg;
  logic          rx_meta_reg;
  logic          rxs_reg;
  logic [CW-1:0] rx_cnt_reg;
  logic [2:0]    rx_bit_reg;
  logic [7:0]    rx_shift_reg;
  logic [7:0]    rx_data_reg;
  logic          rx_valid_reg;
  logic          rx_frame_err_reg;
  logic          rx_overrun_reg;

  tx_state_t     tx_state_reg;
  logic [CW-1:0] tx_cnt_reg;
  logic [2:0]    tx_bit_reg;
  logic [7:0]    tx_shift_reg;
  logic          tx_ready_reg;
  logic          txd_reg;

  assign rx_valid     = rx_valid_reg;
  assign rx_data      = rx_data_reg;
  assign rx_frame_err = rx_frame_err_reg;
  assign rx_overrun   = rx_overrun_reg;
  assign tx_ready     = tx_ready_reg;
  assign uart_txd     = txd_reg;

  always_ff @(posedge clk) begin
    if (!m_aresetn) begin
      rx_meta_reg      <= 1'b1;
      rxs_reg          <= 1'b1;
      rx_state_reg     <= RX_IDLE;
      rx_cnt_reg       <= '0;
      rx_bit_reg       <= '0;
      rx_shift_reg     <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rx_frame_err_reg <= 1'b0;
      rx_overrun_reg   <= 1'b0;
    end else begin
      rx_meta_reg      <= uart_rxd;
      rxs_reg          <= rx_meta_reg;
      rx_frame_err_reg <= 1'b0;
      rx_overrun_reg   <= 1'b0;
      if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
      case (rx_state_reg)
        RX_IDLE: begin
          rx_cnt_reg <= '0;
          if (!rxs_reg) begin
            rx_state_reg <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_state_reg <= rxs_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rxs_reg, rx_shift_reg[7:1]};
            if (rx_bit_reg == 3'd7) begin
              rx_state_reg <= RX_STOP;
            end else begin
              rx_bit_reg <= rx_bit_reg + 3'd1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= RX_IDLE;
            if (rxs_reg) begin
              // A handshake in the same cycle frees the holding register.
              if (!rx_valid_reg || rx_ready) begin
                rx_data_reg  <= rx_shift_reg;
                rx_valid_reg <= 1'b1;
              end else begin
                rx_overrun_reg <= 1'b1;
              end
            end else begin
              rx_frame_err_reg <= 1'b1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!m_aresetn) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_ready_reg <= 1'b0;
      txd_reg      <= 1'b1;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          txd_reg    <= 1'b1;
          tx_cnt_reg <= '0;
          if (tx_ready_reg && tx_valid) begin
            tx_shift_reg <= tx_data;
            tx_ready_reg <= 1'b0;
            txd_reg      <= 1'b0;
            tx_state_reg <= TX_START;
          end else begin
            tx_ready_reg <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            txd_reg      <= tx_shift_reg[0];
            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            tx_state_reg <= TX_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == 3'd7) begin
              txd_reg      <= 1'b1;
              tx_state_reg <= TX_STOP;
            end else begin
              txd_reg      <= tx_shift_reg[0];
              tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
              tx_bit_reg   <= tx_bit_reg + 3'd1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_reg == STOP_LAST) begin
            tx_cnt_reg   <= '0;
            tx_ready_reg <= 1'b1;
            tx_state_reg <= TX_IDLE;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_phy.sv
// Directed bench for uart_phy at 8 clocks per bit: RX timing, glitch, framing,
// overrun, back-to-back TX, mid-frame reset and TX->RX loopback.
module tb_uart_phy;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       m_aresetn = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       loopback = 1'b0;
  logic       rx_ready = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       uart_rxd;
  logic       uart_txd;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;

  int checks = 0;
  int failures = 0;

  assign uart_rxd = loopback ? uart_txd : rxd_drv;

  always #5 clk = ~clk;

  uart_phy #(.CLKS_PER_BIT(N)) dut (
    .clk         (clk),
    .m_aresetn   (m_aresetn),
    .uart_rxd    (uart_rxd),
    .uart_txd    (uart_txd),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame on rxd (j = cycles since the start bit was presented);
  // the deliver/err/overrun outcome becomes visible at j == 79.
  task automatic rx_frame(input string tag, input logic [7:0] d, input logic stop_bit,
                          input logic valid_before, input logic exp_err,
                          input logic exp_ovr, input logic [7:0] exp_data);
    logic [9:0] fr;
    int bad;
    fr  = {stop_bit, d, 1'b0};
    bad = 0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (j == 79) begin
        chk({tag, "_valid"}, 16'(rx_valid), exp_err ? 16'(valid_before) : 16'd1);
        chk({tag, "_frame_err"}, 16'(rx_frame_err), 16'(exp_err));
        chk({tag, "_overrun"}, 16'(rx_overrun), 16'(exp_ovr));
        if (!exp_err) chk({tag, "_data"}, 16'(rx_data), 16'(exp_data));
      end else if (rx_valid !== valid_before || rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
        bad++;
      end
      rxd_drv = (j < 79) ? fr[j / N] : 1'b1;
    end
    chk({tag, "_quiet_before_stop"}, 16'(bad), 16'd0);
  endtask

  task automatic handshake(input string tag, input logic [7:0] exp_data);
    @(negedge clk);
    chk({tag, "_valid_hold"}, 16'(rx_valid), 16'd1);
    chk({tag, "_pulses_clear"}, {14'd0, rx_frame_err, rx_overrun}, 16'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk({tag, "_valid_after_hs"}, 16'(rx_valid), 16'd0);
    chk({tag, "_data_after_hs"}, 16'(rx_data), 16'(exp_data));
  endtask

  task automatic wait_tx_ready(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_tx_ready_wait"}, 16'(ok), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] f1;
    logic [9:0] f2;
    logic       exp_bit;
    int         bad;
    int         rdy_bad;
    logic       got;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_txd", 16'(uart_txd), 16'd1);
    chk("reset_tx_ready", 16'(tx_ready), 16'd0);
    chk("reset_rx_valid", 16'(rx_valid), 16'd0);
    chk("reset_rx_data", 16'(rx_data), 16'd0);
    chk("reset_pulses", {14'd0, rx_frame_err, rx_overrun}, 16'd0);
    m_aresetn = 1'b1;
    @(negedge clk);
    chk("post_reset_tx_ready", 16'(tx_ready), 16'd1);

    // RX 0xA5 with timing, then consumer ready one cycle later
    rx_frame("rx_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    handshake("rx_a5", 8'hA5);
    repeat (10) @(negedge clk);

    // TX 0x55 then 0x12 back-to-back
    f1 = {1'b1, 8'h55, 1'b0};
    f2 = {1'b1, 8'h12, 1'b0};
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    wait_tx_ready("tx_b2b");
    bad = 0;
    rdy_bad = 0;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      if (k == 0) tx_data = 8'h12;
      if (k == 80) tx_valid = 1'b0;
      exp_bit = (k < 80) ? f1[k / N] : f2[(k - 80) / N];
      if (uart_txd !== exp_bit) bad++;
      if (tx_ready !== ((k == 79) || (k == 159))) rdy_bad++;
      if (k % N == N / 2) chk($sformatf("tx_bit%0d", k / N), 16'(uart_txd), 16'(exp_bit));
    end
    chk("tx_line_every_cycle", 16'(bad), 16'd0);
    chk("tx_ready_only_at_accept", 16'(rdy_bad), 16'd0);
    @(negedge clk);
    chk("tx_idle_line_high", 16'(uart_txd), 16'd1);
    chk("tx_idle_ready", 16'(tx_ready), 16'd1);

    // Start-bit glitch: 3 cycles low, then a valid 0x3C
    rxd_drv = 1'b0;
    repeat (3) @(negedge clk);
    rxd_drv = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) bad++;
    end
    chk("glitch_no_activity", 16'(bad), 16'd0);
    rx_frame("rx_3c", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    handshake("rx_3c", 8'h3C);
    repeat (10) @(negedge clk);

    // Framing error: 0x81 with stop bit low
    rx_frame("rx_ferr", 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("ferr_pulse_one_cycle", 16'(rx_frame_err), 16'd0);
    chk("ferr_valid_stays_low", 16'(rx_valid), 16'd0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) bad++;
    end
    chk("ferr_aftermath_quiet", 16'(bad), 16'd0);

    // Overrun: 0x11 then 0x22 without rx_ready
    rx_frame("rx_11", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    rx_frame("rx_22_ovr", 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11);
    handshake("rx_ovr", 8'h11);
    repeat (10) @(negedge clk);

    // Reset in the middle of both a TX and an RX frame
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    wait_tx_ready("midrst");
    @(negedge clk);
    tx_valid = 1'b0;
    chk("midrst_tx_busy", 16'(tx_ready), 16'd0);
    rxd_drv = 1'b0;
    repeat (25) @(negedge clk);
    m_aresetn = 1'b0;
    rxd_drv   = 1'b1;
    @(negedge clk);
    chk("midrst_txd", 16'(uart_txd), 16'd1);
    chk("midrst_rx_valid", 16'(rx_valid), 16'd0);
    chk("midrst_tx_ready", 16'(tx_ready), 16'd0);
    m_aresetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || rx_valid !== 1'b0 || rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) bad++;
    end
    chk("midrst_abandoned", 16'(bad), 16'd0);

    // Loopback 0xC3 through TX into RX
    loopback = 1'b1;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    wait_tx_ready("loop");
    @(negedge clk);
    tx_valid = 1'b0;
    got = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) bad++;
      if (rx_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("loop_rx_valid_seen", 16'(got), 16'd1);
    chk("loop_no_errors", 16'(bad), 16'd0);
    chk("loop_rx_data", 16'(rx_data), 16'h00C3);
    handshake("loop", 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
